serial_full_adder: RTL and testbench
====================================

# serial_full_adder

Bit-serial N-bit adder built around a single full-adder cell and one carry flip-flop. It is the addition counterpart to the lab's full-subtractor datapath. The block accepts two parallel operands and a carry-in on a start pulse, then adds one bit per clock, LSB first. It returns the parallel sum and carry-out with a one-cycle done pulse. It sits between the switch/register front-end and the display logic in the arithmetic lab top level.

## Interface
Parameters:
- WIDTH, 8, operand and sum width in bits (≥2)

Ports:
- clk  input  1  single clock; all state updates on rising edge
- reset_n  input  1  asynchronous, active-low reset
- start  input  1  request to begin an addition; sampled only in IDLE
- a  input  WIDTH  operand A; captured on accepted start
- b  input  WIDTH  operand B; captured on accepted start
- cin  input  1  carry-in; captured on accepted start
- busy  output  1  high in RUN and DONE
- done  output  1  one-cycle pulse; sum/cout valid
- sum  output  WIDTH  result; held from done until next accepted start
- cout  output  1  final carry-out; held like sum
- ovf  output  1  signed overflow (present only with SERIAL_ADDER_OVF_EN)

## Operation
- FSM states: IDLE, RUN, DONE.
  - IDLE → RUN on start=1. Load shift registers sa←a, sb←b; carry←cin; count←0.
  - RUN: on each edge compute s=sa[0]^sb[0]^carry and c=majority(sa[0],sb[0],carry).
    - Shift sa and sb right by one.
    - Shift s into sum register MSB (sum register shifts right).
    - carry←c; count←count+1.
    - After the edge where count reaches WIDTH-1, go to DONE.
  - DONE → IDLE unconditionally. done=1 in DONE only.
- count width is $clog2(WIDTH). It never wraps past WIDTH-1.
- cout = carry register value after the final RUN edge.
- start is ignored in RUN and DONE. It is not queued; a start held high in DONE is accepted in the following IDLE cycle.
- a, b and cin may change freely after acceptance without affecting the result.
- sum and cout are not cleared on start. They change bit-by-bit during RUN and are valid only while done=1 and in the IDLE period that follows.
- Reset (reset_n=0, any time, including mid-RUN):
  - state=IDLE, busy=0, done=0, sum=0, cout=0, ovf=0, count=0, carry=0.
  - Any operation in progress is abandoned.

## Timing
- Accepted start at edge k gives RUN for edges k+1 … k+WIDTH.
- done is high for exactly one cycle, from edge k+WIDTH to edge k+WIDTH+1.
- Latency from start to done is WIDTH cycles. Throughput is one addition per WIDTH+2 cycles if start is held high.
- busy rises at edge k and falls at edge k+WIDTH+1.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Configuration
- SERIAL_ADDER_OVF_EN defined:
  - The ovf port exists.
  - On the final RUN edge, ovf←(carry into MSB) XOR (carry out of MSB).
  - ovf is held with sum.
- SERIAL_ADDER_OVF_EN not defined:
  - No ovf port and no associated flop.
  - All other behaviour is identical.

## Test plan
- WIDTH=8, a=0x5A, b=0x3C, cin=0, start pulse → done exactly 8 cycles after start edge; sum=0x96, cout=0, ovf=1.
- a=0xFF, b=0x01, cin=0 → sum=0x00, cout=1, ovf=0. Then a=0x7F, b=0x00, cin=1 → sum=0x80, cout=0, ovf=1.
- Exhaustive sweep at WIDTH=4 over all a, b, cin (512 cases) → {cout,sum} == a+b+cin for every case; done pulse width is always 1 cycle.
- Start with a=0x12, b=0x34; pulse start again with a=0xFF, b=0xFF at cycle 3 of RUN → second start ignored; sum=0x46, cout=0; busy never drops mid-operation.
- Assert reset_n=0 at cycle 4 of RUN → busy, done, sum and cout go to 0 immediately (asynchronously). After release, a fresh start with a=0x01, b=0x01 → sum=0x02.
- start held high continuously with constant operands → done pulses every 10 cycles (WIDTH+2); sum is stable at the same value each time.

Source files
------------

// File: rtl/serial_full_adder.sv
// Bit-serial WIDTH-bit adder: one full-adder cell plus a carry flop, LSB first.
// Define SERIAL_ADDER_OVF_EN to add the signed-overflow output ovf.
module serial_full_adder #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
`ifdef SERIAL_ADDER_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] sa_q, sa_d;
  logic [WIDTH-1:0] sb_q, sb_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             carry_q, carry_d;
  logic             cout_q, cout_d;
  logic [CW-1:0]    count_q, count_d;
  logic             sBit, cBit, lastBit;
`ifdef SERIAL_ADDER_OVF_EN
  logic             ovf_q, ovf_d;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      sa_q    <= '0;
      sb_q    <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      count_q <= '0;
`ifdef SERIAL_ADDER_OVF_EN
      ovf_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      sa_q    <= sa_d;
      sb_q    <= sb_d;
      sum_q   <= sum_d;
      carry_q <= carry_d;
      cout_q  <= cout_d;
      count_q <= count_d;
`ifdef SERIAL_ADDER_OVF_EN
      ovf_q   <= ovf_d;
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    sa_d    = sa_q;
    sb_d    = sb_q;
    sum_d   = sum_q;
    carry_d = carry_q;
    cout_d  = cout_q;
    count_d = count_q;
`ifdef SERIAL_ADDER_OVF_EN
    ovf_d   = ovf_q;
`endif
    sBit    = sa_q[0] ^ sb_q[0] ^ carry_q;
    cBit    = (sa_q[0] & sb_q[0]) | (sa_q[0] & carry_q) | (sb_q[0] & carry_q);
    lastBit = (count_q == CW'(WIDTH - 1));

    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = RUN;
          sa_d    = a;
          sb_d    = b;
          carry_d = cin;
          count_d = '0;
        end
      end
      RUN: begin
        sa_d    = sa_q >> 1;
        sb_d    = sb_q >> 1;
        sum_d   = {sBit, sum_q[WIDTH-1:1]};
        carry_d = cBit;
        // The counter holds at WIDTH-1 on the final bit instead of wrapping.
        if (lastBit) begin
          state_d = DONE;
          cout_d  = cBit;
`ifdef SERIAL_ADDER_OVF_EN
          ovf_d   = carry_q ^ cBit;
`endif
        end else begin
          count_d = count_q + 1'b1;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign busy = (state_q != IDLE);
  assign done = (state_q == DONE);
  assign sum  = sum_q;
  assign cout = cout_q;
`ifdef SERIAL_ADDER_OVF_EN
  assign ovf  = ovf_q;
`endif

endmodule

// File: tb/tb_serial_full_adder.sv
// Scoreboard bench for serial_full_adder: an 8-bit instance for directed vectors
// and a 4-bit instance for the full operand sweep.
module tb_serial_full_adder;

  typedef struct {
    logic [7:0] sum;
    logic       cout;
    logic       ovf;
    int         cyc;
  } exp_t;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       start8, cin8, busy8, done8, cout8;
  logic [7:0] a8, b8, sum8;
  logic       start4, cin4, busy4, done4, cout4;
  logic [3:0] a4, b4, sum4;
`ifdef SERIAL_ADDER_OVF_EN
  logic       ovf8, ovf4;
`endif

  exp_t q8[$];
  exp_t q4[$];
  exp_t e8, e4;
  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;
  logic prevDone8 = 1'b0;
  logic prevDone4 = 1'b0;

  serial_full_adder #(.WIDTH(8)) u_dut8 (
    .clk(clk), .reset_n(reset_n), .start(start8), .a(a8), .b(b8), .cin(cin8),
    .busy(busy8), .done(done8), .sum(sum8), .cout(cout8)
`ifdef SERIAL_ADDER_OVF_EN
    , .ovf(ovf8)
`endif
  );

  serial_full_adder #(.WIDTH(4)) u_dut4 (
    .clk(clk), .reset_n(reset_n), .start(start4), .a(a4), .b(b4), .cin(cin4),
    .busy(busy4), .done(done4), .sum(sum4), .cout(cout4)
`ifdef SERIAL_ADDER_OVF_EN
    , .ovf(ovf4)
`endif
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s actual=0x%0h expected=0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Each result pops the oldest expectation, including the edge it should land on.
  always @(negedge clk) begin
    if (reset_n && done8) begin
      checkOutput("donePulse8", {31'd0, prevDone8}, 32'd0);
      if (q8.size() == 0) begin
        failures++;
        $display("[TB] FAIL unexpectedDone8 actual=done expected=no_done");
      end else begin
        e8 = q8.pop_front();
        checkOutput("sum8", {24'd0, sum8}, {24'd0, e8.sum});
        checkOutput("cout8", {31'd0, cout8}, {31'd0, e8.cout});
        checkOutput("doneCycle8", cyc, e8.cyc);
`ifdef SERIAL_ADDER_OVF_EN
        checkOutput("ovf8", {31'd0, ovf8}, {31'd0, e8.ovf});
`endif
      end
    end
    prevDone8 <= done8;
  end

  always @(negedge clk) begin
    if (reset_n && done4) begin
      checkOutput("donePulse4", {31'd0, prevDone4}, 32'd0);
      if (q4.size() == 0) begin
        failures++;
        $display("[TB] FAIL unexpectedDone4 actual=done expected=no_done");
      end else begin
        e4 = q4.pop_front();
        checkOutput("sum4", {28'd0, sum4}, {24'd0, e4.sum});
        checkOutput("cout4", {31'd0, cout4}, {31'd0, e4.cout});
        checkOutput("doneCycle4", cyc, e4.cyc);
`ifdef SERIAL_ADDER_OVF_EN
        checkOutput("ovf4", {31'd0, ovf4}, {31'd0, e4.ovf});
`endif
      end
    end
    prevDone4 <= done4;
  end

  // Issues one start at a negedge, so the accepting edge is the next posedge.
  task automatic applyStimulus(input logic [7:0] a, input logic [7:0] b, input logic cin,
                               input logic [7:0] expSum, input logic expCout, input logic expOvf);
    int n = 0;
    exp_t e;
    while (busy8 && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (busy8) checkOutput("idleTimeout8", {31'd0, busy8}, 32'd0);
    a8 = a; b8 = b; cin8 = cin; start8 = 1'b1;
    e.sum = expSum; e.cout = expCout; e.ovf = expOvf; e.cyc = cyc + 1 + 8;
    q8.push_back(e);
    @(negedge clk);
    start8 = 1'b0;
    a8 = ~a; b8 = ~b; cin8 = ~cin;
  endtask

  task automatic applyStimulus4(input logic [3:0] a, input logic [3:0] b, input logic cin);
    int n = 0;
    exp_t e;
    logic [4:0] tot;
    while (busy4 && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (busy4) checkOutput("idleTimeout4", {31'd0, busy4}, 32'd0);
    tot = {1'b0, a} + {1'b0, b} + {4'd0, cin};
    a4 = a; b4 = b; cin4 = cin; start4 = 1'b1;
    e.sum = {4'd0, tot[3:0]};
    e.cout = tot[4];
    e.ovf = (a[3] == b[3]) && (tot[3] != a[3]);
    e.cyc = cyc + 1 + 4;
    q4.push_back(e);
    @(negedge clk);
    start4 = 1'b0;
    a4 = ~a; b4 = ~b; cin4 = ~cin;
  endtask

  initial begin
    int n;
    exp_t e;
    reset_n = 1'b0;
    start8 = 1'b0; a8 = '0; b8 = '0; cin8 = 1'b0;
    start4 = 1'b0; a4 = '0; b4 = '0; cin4 = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("rstBusy", {31'd0, busy8}, 32'd0);
    checkOutput("rstDone", {31'd0, done8}, 32'd0);
    checkOutput("rstSum", {24'd0, sum8}, 32'd0);
    checkOutput("rstCout", {31'd0, cout8}, 32'd0);
    reset_n = 1'b1;
    @(negedge clk);

    applyStimulus(8'h5A, 8'h3C, 1'b0, 8'h96, 1'b0, 1'b1);
    checkOutput("busyRise", {31'd0, busy8}, 32'd1);
    applyStimulus(8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0);
    applyStimulus(8'h7F, 8'h00, 1'b1, 8'h80, 1'b0, 1'b1);

    // A second start mid-run must be ignored and busy must stay high.
    applyStimulus(8'h12, 8'h34, 1'b0, 8'h46, 1'b0, 1'b0);
    for (int i = 1; i <= 8; i++) begin
      if (i == 2) begin
        start8 = 1'b1; a8 = 8'hFF; b8 = 8'hFF;
      end
      if (i == 3) start8 = 1'b0;
      checkOutput("busyHeld", {31'd0, busy8}, 32'd1);
      @(negedge clk);
    end

    // Asynchronous reset during RUN clears the outputs without a clock edge.
    applyStimulus(8'h0F, 8'h0F, 1'b0, 8'h1E, 1'b0, 1'b0);
    repeat (3) @(negedge clk);
    #1 reset_n = 1'b0;
    q8.delete();
    #1;
    checkOutput("arstBusy", {31'd0, busy8}, 32'd0);
    checkOutput("arstDone", {31'd0, done8}, 32'd0);
    checkOutput("arstSum", {24'd0, sum8}, 32'd0);
    checkOutput("arstCout", {31'd0, cout8}, 32'd0);
    @(posedge clk);
    #1 reset_n = 1'b1;
    @(negedge clk);
    applyStimulus(8'h01, 8'h01, 1'b0, 8'h02, 1'b0, 1'b0);

    // Start held high: one addition every WIDTH+2 cycles.
    n = 0;
    while (busy8 && n < 100) begin
      @(negedge clk);
      n++;
    end
    a8 = 8'h21; b8 = 8'h43; cin8 = 1'b1; start8 = 1'b1;
    for (int i = 0; i < 3; i++) begin
      e.sum = 8'h65; e.cout = 1'b0; e.ovf = 1'b0; e.cyc = cyc + 1 + 8 + 10 * i;
      q8.push_back(e);
    end
    repeat (30) @(negedge clk);
    start8 = 1'b0;

    for (int ai = 0; ai < 16; ai++)
      for (int bi = 0; bi < 16; bi++)
        for (int ci = 0; ci < 2; ci++)
          applyStimulus4(4'(ai), 4'(bi), 1'(ci));

    n = 0;
    while ((q8.size() != 0 || q4.size() != 0) && n < 200) begin
      @(negedge clk);
      n++;
    end
    checkOutput("drain8", q8.size(), 32'd0);
    checkOutput("drain4", q4.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
